// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [PC_WIDTH-1:0]   req_addr;
  logic                  resp_valid;
  logic [INST_WIDTH-1:0] resp_data;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [INST_WIDTH-1:0] out_inst;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_inst,
    input  req_ready, resp_valid, resp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_inst,
    output req_ready, resp_valid, resp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding memory read, small PC/instruction FIFO
// towards decode, and redirect handling that flushes buffered and in-flight fetches.
module fetch_unit #(
  parameter int                  PC_WIDTH   = 64,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int                  DEPTH      = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]    PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(3'd4);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetchState_e;

  fetchState_e           state_r;
  fetchState_e           stateNext_s;
  logic [PC_WIDTH-1:0]   fetchPc_r;
  logic [PC_WIDTH-1:0]   fetchPcNext_s;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      countNext_s;
  logic [PTR_W-1:0]      wrPtr_r;
  logic [PTR_W-1:0]      wrPtrNext_s;
  logic [PTR_W-1:0]      rdPtr_r;
  logic [PTR_W-1:0]      rdPtrNext_s;
  logic                  reqValid_r;
  logic                  reqValidNext_s;
  logic                  nonEmpty_r;
  logic                  reqFire_s;
  logic                  pushEn_s;
  logic                  popEn_s;
  logic                  outValid_s;
  logic [PC_WIDTH-1:0]   redirectAligned_s;
  logic [PC_WIDTH-1:0]   pcMem_r   [DEPTH];
  logic [INST_WIDTH-1:0] instMem_r [DEPTH];

  // Handshake qualifiers; a redirect masks the head entry because it is being flushed.
  always_comb begin
    outValid_s        = nonEmpty_r & ~bus.redirect_valid;
    reqFire_s         = reqValid_r & bus.req_ready;
    pushEn_s          = (state_r == WAIT) & bus.resp_valid & ~bus.redirect_valid;
    popEn_s           = outValid_s & bus.out_ready;
    redirectAligned_s = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
  end

  // Next-state logic: WAIT/DRAIN always return to REQ on a response, redirect only
  // changes the path when a request is (or stays) outstanding.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      REQ: begin
        if (reqFire_s) begin
          stateNext_s = bus.redirect_valid ? DRAIN : WAIT;
        end else begin
          stateNext_s = REQ;
        end
      end
      WAIT: begin
        if (bus.resp_valid) begin
          stateNext_s = REQ;
        end else if (bus.redirect_valid) begin
          stateNext_s = DRAIN;
        end else begin
          stateNext_s = WAIT;
        end
      end
      DRAIN: begin
        if (bus.resp_valid) begin
          stateNext_s = REQ;
        end else begin
          stateNext_s = DRAIN;
        end
      end
      default: begin
        stateNext_s = REQ;
      end
    endcase
  end

  // Fetch PC and FIFO bookkeeping; redirect overrides any push or pop.
  always_comb begin
    fetchPcNext_s = fetchPc_r;
    countNext_s   = count_r;
    wrPtrNext_s   = wrPtr_r;
    rdPtrNext_s   = rdPtr_r;
    if (bus.redirect_valid) begin
      fetchPcNext_s = redirectAligned_s;
      countNext_s   = CNT_ZERO;
      wrPtrNext_s   = PTR_ZERO;
      rdPtrNext_s   = PTR_ZERO;
    end else begin
      if (pushEn_s) begin
        fetchPcNext_s = fetchPc_r + PC_STEP;
        wrPtrNext_s   = wrPtr_r + PTR_ONE;
      end else begin
        fetchPcNext_s = fetchPc_r;
      end
      if (popEn_s) begin
        rdPtrNext_s = rdPtr_r + PTR_ONE;
      end else begin
        rdPtrNext_s = rdPtr_r;
      end
      countNext_s = count_r + CNT_W'(pushEn_s) - CNT_W'(popEn_s);
    end
  end

  // Request-valid is computed from next state so it leaves a flop yet matches the
  // combinational "REQ and not full" definition cycle for cycle.
  always_comb begin
    reqValidNext_s = (stateNext_s == REQ) && (countNext_s < DEPTH_C);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= REQ;
      fetchPc_r  <= RESET_PC;
      count_r    <= CNT_ZERO;
      wrPtr_r    <= PTR_ZERO;
      rdPtr_r    <= PTR_ZERO;
      reqValid_r <= 1'b0;
      nonEmpty_r <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      fetchPc_r  <= fetchPcNext_s;
      count_r    <= countNext_s;
      wrPtr_r    <= wrPtrNext_s;
      rdPtr_r    <= rdPtrNext_s;
      reqValid_r <= reqValidNext_s;
      nonEmpty_r <= (countNext_s != CNT_ZERO);
    end
  end

  // FIFO storage; entries are cleared on reset so the head reads zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcMem_r[i]   <= {PC_WIDTH{1'b0}};
        instMem_r[i] <= {INST_WIDTH{1'b0}};
      end
    end else begin
      if (pushEn_s) begin
        pcMem_r[wrPtr_r]   <= fetchPc_r;
        instMem_r[wrPtr_r] <= bus.resp_data;
      end
    end
  end

  assign bus.req_valid = reqValid_r;
  assign bus.req_addr  = fetchPc_r;
  assign bus.out_valid = outValid_s;
  assign bus.out_pc    = pcMem_r[rdPtr_r];
  assign bus.out_inst  = instMem_r[rdPtr_r];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays instruction memory, execute and
// decode, and checks every observation with an immediate assertion.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  fetch_unit_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

  fetch_unit #(
    .PC_WIDTH  (64),
    .INST_WIDTH(32),
    .RESET_PC  (64'h0000_0000_8000_0000),
    .DEPTH     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] addr);
    return addr[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full fetch: request accepted, then response on the following cycle.
  task automatic issue(input logic [63:0] addr);
    check("issue_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("issue_req_addr", bus.req_addr, addr);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("wait_req_valid", {63'd0, bus.req_valid}, 64'd0);
    bus.resp_valid = 1'b1;
    bus.resp_data  = word(addr);
    tick();
    bus.resp_valid = 1'b0;
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [63:0] pc);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, {63'd0, v});
    if (v) begin
      check({tag, "_pc"}, bus.out_pc, pc);
      check({tag, "_inst"}, {32'd0, bus.out_inst}, {32'd0, word(pc)});
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req_valid"}, {63'd0, bus.req_valid}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_out_pc"}, bus.out_pc, 64'd0);
    check({tag, "_out_inst"}, {32'd0, bus.out_inst}, 64'd0);
    check({tag, "_req_addr"}, bus.req_addr, 64'h0000_0000_8000_0000);
  endtask

  initial begin
    assertCount        = 0;
    failCount          = 0;
    rst                = 1'b1;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    bus.out_ready      = 1'b1;

    // Reset state
    tick();
    checkResetOutputs("reset");
    rst = 1'b0;
    tick();

    // 1: streaming fetch with decode always ready
    issue(64'h0000_0000_8000_0000);
    checkOut("t1_e0", 1'b1, 64'h0000_0000_8000_0000);
    issue(64'h0000_0000_8000_0004);
    checkOut("t1_e1", 1'b1, 64'h0000_0000_8000_0004);
    issue(64'h0000_0000_8000_0008);
    checkOut("t1_e2", 1'b1, 64'h0000_0000_8000_0008);
    check("t1_next_addr", bus.req_addr, 64'h0000_0000_8000_000C);

    // 2: decode stalled -> FIFO fills to two entries and issue stops
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    issue(64'h0000_0000_8000_0000);
    issue(64'h0000_0000_8000_0004);
    for (int i = 0; i < 8; i++) begin
      check("t2_full_req_valid", {63'd0, bus.req_valid}, 64'd0);
      checkOut("t2_head", 1'b1, 64'h0000_0000_8000_0000);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checkOut("t2_second", 1'b1, 64'h0000_0000_8000_0004);
    issue(64'h0000_0000_8000_0008);
    checkOut("t2_resume", 1'b1, 64'h0000_0000_8000_0008);

    // 3: redirect while waiting for a response
    bus.out_ready = 1'b0;
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    checkOut("t3_pre", 1'b1, 64'h0000_0000_8000_0008);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_1002;
    #1;
    check("t3_mask_out_valid", {63'd0, bus.out_valid}, 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_drain_req_valid", {63'd0, bus.req_valid}, 64'd0);
    checkOut("t3_flushed", 1'b0, 64'd0);
    check("t3_target", bus.req_addr, 64'h0000_0000_8000_1000);
    bus.resp_valid = 1'b1;
    bus.resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.resp_valid = 1'b0;
    checkOut("t3_discard", 1'b0, 64'd0);
    issue(64'h0000_0000_8000_1000);
    checkOut("t3_new", 1'b1, 64'h0000_0000_8000_1000);

    // 4: redirect coinciding with the response
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b1;
    bus.resp_data      = word(64'h0000_0000_8000_1004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_4000_0013;
    tick();
    bus.resp_valid     = 1'b0;
    bus.redirect_valid = 1'b0;
    check("t4_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("t4_req_addr", bus.req_addr, 64'h0000_0000_4000_0010);
    checkOut("t4_not_pushed", 1'b0, 64'd0);

    // 5: PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check("t5_target", bus.req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    issue(64'hFFFF_FFFF_FFFF_FFFC);
    checkOut("t5_entry", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_wrap_addr", bus.req_addr, 64'd0);
    check("t5_wrap_valid", {63'd0, bus.req_valid}, 64'd1);

    // Redirect in the same cycle the request is accepted -> response must be dropped
    bus.req_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_0000_0100;
    tick();
    bus.req_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    check("acc_drain_req_valid", {63'd0, bus.req_valid}, 64'd0);
    check("acc_target", bus.req_addr, 64'h0000_0000_0000_0100);
    bus.resp_valid = 1'b1;
    bus.resp_data  = 32'h0BAD_F00D;
    tick();
    bus.resp_valid = 1'b0;
    checkOut("acc_discard", 1'b0, 64'd0);
    check("acc_req_valid", {63'd0, bus.req_valid}, 64'd1);

    // 6: asynchronous reset while a request is outstanding with data buffered
    issue(64'h0000_0000_0000_0100);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    checkOut("t6_pre", 1'b1, 64'h0000_0000_0000_0100);
    rst = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    tick();
    rst = 1'b0;
    tick();
    check("t6_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("t6_req_addr", bus.req_addr, 64'h0000_0000_8000_0000);
    checkOut("t6_empty", 1'b0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
